// File: rtl/uart_fifo_rx_if.sv
// Byte handshake between the UART receiver engine, the RX FIFO and the bus read port.
// Signal names follow the FIFO's point of view.
interface uart_fifo_rx_if;
  logic       wr_en_i;
  logic [7:0] data_i;
  logic       frame_err_i;
  logic       rd_en_i;
  logic [7:0] data_o;
  logic       frame_err_o;
  logic       rd_valid_o;

  modport master (
    output wr_en_i, data_i, frame_err_i, rd_en_i,
    input  data_o, frame_err_o, rd_valid_o
  );

  modport slave (
    input  wr_en_i, data_i, frame_err_i, rd_en_i,
    output data_o, frame_err_o, rd_valid_o
  );
endinterface

// File: rtl/uart_fifo_rx.sv
// UART receive FIFO: circular buffer of {frame_err, data} entries with an occupancy
// counter, full/empty/watermark interrupt sources and a sticky overflow flag.
module uart_fifo_rx #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  uart_fifo_rx_if.slave bus,
  input  logic [AW:0]   thresh_i,
  input  logic          ovf_clr_i,
  output logic [AW:0]   level_o,
  output logic          intr_full_o,
  output logic          intr_empty_o,
  output logic          intr_thresh_o,
  output logic          overflow_o
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [7:0]    data_q, data_d;
  logic          ferr_q, ferr_d;
  logic          rv_q, rv_d;
  logic          ovf_q, ovf_d;
  logic          rd_acc, wr_acc;

  // A write on full is still accepted when a read frees a slot in the same cycle.
  assign rd_acc = bus.rd_en_i && (level_q != '0);
  assign wr_acc = bus.wr_en_i && ((level_q != LVL_FULL) || rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    data_d   = data_q;
    ferr_d   = ferr_q;
    rv_d     = 1'b0;
    ovf_d    = ovf_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (rd_acc) begin
        {ferr_d, data_d} = mem_q[rd_ptr_q];
        rd_ptr_d         = rd_ptr_q + 1'b1;
        rv_d             = 1'b1;
      end
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (bus.wr_en_i && !wr_acc) begin
        ovf_d = 1'b1;
      end else if (ovf_clr_i) begin
        ovf_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      data_q   <= '0;
      ferr_q   <= 1'b0;
      rv_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      data_q   <= data_d;
      ferr_q   <= ferr_d;
      rv_q     <= rv_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !clr_i && wr_acc) begin
      mem_q[wr_ptr_q] <= {bus.frame_err_i, bus.data_i};
    end
  end

  assign bus.data_o      = data_q;
  assign bus.frame_err_o = ferr_q;
  assign bus.rd_valid_o  = rv_q;
  assign level_o         = level_q;
  assign overflow_o      = ovf_q;
  assign intr_full_o     = (level_q == LVL_FULL);
  assign intr_empty_o    = (level_q == '0);
  assign intr_thresh_o   = (thresh_i != '0) && (level_q >= thresh_i);

endmodule

// File: tb/tb_uart_fifo_rx.sv
// Bench for uart_fifo_rx: directed vector table, hand sequences for the corner cases,
// and random traffic checked against a queue-based reference model.
module tb_uart_fifo_rx;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [3:0] th = 4'd0;
  logic [3:0] level;
  logic       full, empty, thr, ovf;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [8:0] mq[$];
  logic [7:0] m_d = 8'h00;
  logic       m_fe = 1'b0;
  logic       m_rv = 1'b0;
  logic       m_ovf = 1'b0;

  uart_fifo_rx_if bus ();

  uart_fifo_rx #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .bus(bus),
    .thresh_i(th), .ovf_clr_i(ovf_clr), .level_o(level),
    .intr_full_o(full), .intr_empty_o(empty), .intr_thresh_o(thr), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst, clr, wr; logic [7:0] din; bit fe, rd, oc; logic [3:0] th;
    int lvl; bit rv; logic [7:0] dout; bit dfe, ovf, thr;
  } vec_t;

  function automatic vec_t mk(int r, int c, int w, int din, int fe, int rd, int oc, int t,
                              int lvl, int rv, int dout, int dfe, int ov, int tr);
    vec_t v;
    v.rst = (r != 0); v.clr = (c != 0); v.wr = (w != 0); v.din = 8'(din);
    v.fe = (fe != 0); v.rd = (rd != 0); v.oc = (oc != 0); v.th = 4'(t);
    v.lvl = lvl; v.rv = (rv != 0); v.dout = 8'(dout); v.dfe = (dfe != 0);
    v.ovf = (ov != 0); v.thr = (tr != 0);
    return v;
  endfunction

  function automatic void chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_step(bit r, bit c, bit w, logic [7:0] d, bit f, bit rd, bit oc);
    bit rdok, wrok;
    logic [8:0] e;
    if (r) begin
      mq.delete(); m_d = 8'h00; m_fe = 1'b0; m_rv = 1'b0; m_ovf = 1'b0;
    end else if (c) begin
      mq.delete(); m_rv = 1'b0; m_ovf = 1'b0;
    end else begin
      rdok = rd && (mq.size() != 0);
      wrok = w && ((mq.size() != DEPTH) || rdok);
      m_rv = rdok;
      if (rdok) begin
        e = mq.pop_front();
        {m_fe, m_d} = e;
      end
      if (wrok) mq.push_back({f, d});
      if (w && !wrok) m_ovf = 1'b1;
      else if (oc) m_ovf = 1'b0;
    end
  endfunction

  function automatic void check_model();
    int n;
    n = mq.size();
    chk("level", int'(level), n);
    chk("full", int'(full), int'(n == DEPTH));
    chk("empty", int'(empty), int'(n == 0));
    chk("thresh", int'(thr), int'(th != 0 && n >= int'(th)));
    chk("overflow", int'(ovf), int'(m_ovf));
    chk("rd_valid", int'(bus.rd_valid_o), int'(m_rv));
    chk("data", int'(bus.data_o), int'(m_d));
    chk("frame_err", int'(bus.frame_err_o), int'(m_fe));
  endfunction

  task automatic step(input bit r, input bit c, input bit w, input logic [7:0] d,
                      input bit f, input bit rd, input bit oc);
    rst = r; clr = c; ovf_clr = oc;
    bus.wr_en_i = w; bus.data_i = d; bus.frame_err_i = f; bus.rd_en_i = rd;
    @(posedge clk);
    #1;
    model_step(r, c, w, d, f, rd, oc);
    check_model();
    rst = 1'b0; clr = 1'b0; ovf_clr = 1'b0;
    bus.wr_en_i = 1'b0; bus.rd_en_i = 1'b0; bus.frame_err_i = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d, input bit f = 1'b0);
    step(1'b0, 1'b0, 1'b1, d, f, 1'b0, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  vec_t tbl[16];

  initial begin
    bus.wr_en_i = 1'b0; bus.data_i = 8'h00; bus.frame_err_i = 1'b0; bus.rd_en_i = 1'b0;

    //            rst clr wr din  fe rd oc th | lvl rv dout dfe ovf thr
    tbl[0]  = mk(1, 0, 0, 'h00, 0, 0, 0, 4,   0, 0, 'h00, 0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 'h55, 1, 0, 0, 4,   1, 0, 'h00, 0, 0, 0);
    tbl[2]  = mk(0, 0, 1, 'h12, 0, 0, 0, 4,   2, 0, 'h00, 0, 0, 0);
    tbl[3]  = mk(0, 0, 1, 'h34, 0, 0, 0, 4,   3, 0, 'h00, 0, 0, 0);
    tbl[4]  = mk(0, 0, 1, 'h56, 0, 0, 0, 4,   4, 0, 'h00, 0, 0, 1);
    tbl[5]  = mk(0, 0, 0, 'h00, 0, 1, 0, 4,   3, 1, 'h55, 1, 0, 0);
    tbl[6]  = mk(0, 0, 0, 'h00, 0, 0, 0, 4,   3, 0, 'h55, 1, 0, 0);
    tbl[7]  = mk(0, 0, 1, 'h78, 0, 1, 0, 4,   3, 1, 'h12, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 'h00, 0, 1, 0, 4,   2, 1, 'h34, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 'h00, 0, 1, 0, 4,   1, 1, 'h56, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 'h00, 0, 1, 0, 4,   0, 1, 'h78, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 'h00, 0, 1, 0, 4,   0, 0, 'h78, 0, 0, 0);
    tbl[12] = mk(0, 0, 1, 'h9A, 0, 1, 0, 4,   1, 0, 'h78, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 'h00, 0, 0, 1, 1,   1, 0, 'h78, 0, 0, 1);
    tbl[14] = mk(0, 0, 0, 'h00, 0, 1, 0, 1,   0, 1, 'h9A, 0, 0, 0);
    tbl[15] = mk(0, 1, 1, 'hEE, 0, 0, 0, 1,   0, 0, 'h9A, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      th = tbl[i].th;
      step(tbl[i].rst, tbl[i].clr, tbl[i].wr, tbl[i].din, tbl[i].fe, tbl[i].rd, tbl[i].oc);
      chk($sformatf("tbl%0d.level", i), int'(level), tbl[i].lvl);
      chk($sformatf("tbl%0d.rv", i), int'(bus.rd_valid_o), int'(tbl[i].rv));
      chk($sformatf("tbl%0d.data", i), int'(bus.data_o), int'(tbl[i].dout));
      chk($sformatf("tbl%0d.fe", i), int'(bus.frame_err_o), int'(tbl[i].dfe));
      chk($sformatf("tbl%0d.ovf", i), int'(ovf), int'(tbl[i].ovf));
      chk($sformatf("tbl%0d.thr", i), int'(thr), int'(tbl[i].thr));
    end

    // Fill, overflow, set-beats-clear, then clear
    th = 4'd4;
    for (int i = 0; i < DEPTH; i++) wr(8'(8'h11 + i));
    chk("fill.full", int'(full), 1);
    wr(8'hAA);
    chk("ovf.set", int'(ovf), 1);
    step(1'b0, 1'b0, 1'b1, 8'hAB, 1'b0, 1'b0, 1'b1);
    chk("ovf.set_beats_clr", int'(ovf), 1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf.clr", int'(ovf), 0);

    // Simultaneous read+write on full: oldest out, new byte last
    step(1'b0, 1'b0, 1'b1, 8'hC0, 1'b0, 1'b1, 1'b0);
    chk("fullrw.level", int'(level), DEPTH);
    chk("fullrw.data", int'(bus.data_o), 'h11);
    for (int i = 0; i < DEPTH; i++) rd();
    chk("drain.last", int'(bus.data_o), 'hC0);

    // Watermark disabled and above DEPTH
    th = 4'd0;
    for (int i = 0; i < DEPTH; i++) wr(8'($urandom), 1'($urandom));
    th = 4'd9;
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    th = 4'd8;
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) rd();

    // Wrap-around with interleaved pairs
    th = 4'd3;
    for (int i = 0; i < 20; i++) begin
      wr(8'(i * 7 + 3), 1'(i % 3 == 0));
      rd();
    end

    // Flush at level 5 with a same-cycle write
    for (int i = 0; i < 5; i++) wr(8'(8'hA0 + i));
    rd();
    wr(8'hA5);
    step(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    chk("flush.empty", int'(empty), 1);
    chk("flush.data_hold", int'(bus.data_o), 'hA0);

    // Reset mid-operation discards everything
    for (int i = 0; i < 3; i++) wr(8'(8'h60 + i));
    step(1'b1, 1'b0, 1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    wr(8'h42);
    rd();
    chk("rst.first", int'(bus.data_o), 'h42);

    // Random traffic, alternating fill-biased and drain-biased phases
    for (int i = 0; i < 3000; i++) begin
      bit fillp;
      fillp = ((i / 64) % 2) == 0;
      if (i % 100 == 0) th = 4'($urandom_range(0, 15));
      step($urandom_range(0, 299) == 0, $urandom_range(0, 149) == 0,
           fillp ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
           8'($urandom), 1'($urandom),
           fillp ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
           $urandom_range(0, 15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_fifo_rx.md
Name: uart_fifo_rx

Overview:
Receive-side FIFO of the UART peripheral. The UART receiver engine writes each deserialised byte, tagged with its frame-error flag. The bus/register interface reads bytes out.
Implemented as a circular buffer with an occupancy counter. Provides full/empty/watermark interrupt sources and a sticky overflow flag, giving the RX path the same role the TX FIFO has on the transmit path.

Parameters:
DEPTH, 8, number of entries; power of two, minimum 2
AW, $clog2(DEPTH), pointer width; derived localparam, not overridable

Ports:
clk_i  input  1  system clock, all logic on rising edge
rst_i  input  1  synchronous reset, active-high
clr_i  input  1  synchronous FIFO flush, active-high, one cycle
wr_en_i  input  1  receiver byte strobe, one-cycle pulse per received byte
data_i  input  8  received byte, valid with wr_en_i
frame_err_i  input  1  stop-bit error flag for data_i, valid with wr_en_i
rd_en_i  input  1  bus read request, one-cycle pulse
data_o  output  8  registered read data
frame_err_o  output  1  frame-error tag of the byte on data_o
rd_valid_o  output  1  one-cycle pulse: data_o/frame_err_o updated by an accepted read
thresh_i  input  AW+1  watermark level; 0 disables intr_thresh_o
ovf_clr_i  input  1  clears the sticky overflow flag
level_o  output  AW+1  current occupancy, range 0..DEPTH
intr_full_o  output  1  level_o == DEPTH
intr_empty_o  output  1  level_o == 0
intr_thresh_o  output  1  thresh_i != 0 and level_o >= thresh_i
overflow_o  output  1  sticky: a write was dropped because the FIFO was full

Behaviour:
- Storage: DEPTH x 9-bit entries holding {frame_err, data}. Storage is not reset; contents are don't-care until written.
- State: wr_ptr and rd_ptr of width AW, wrapping modulo DEPTH; level register of width AW+1.
- Flags: intr_full_o, intr_empty_o and intr_thresh_o are combinational from the level register and thresh_i. level_o is the register itself.
- Reset (rst_i=1 at the clock edge), highest priority:
  - wr_ptr=rd_ptr=0, level=0
  - data_o=0, frame_err_o=0, rd_valid_o=0, overflow_o=0
  - result: intr_empty_o=1, intr_full_o=0
- Flush (clr_i=1, rst_i=0), priority over reads and writes:
  - wr_ptr=rd_ptr=0, level=0, overflow_o=0, rd_valid_o=0
  - data_o and frame_err_o hold their values
  - any wr_en_i/rd_en_i in the same cycle is dropped, and overflow does not set
- Read accept: rd_acc = rd_en_i && level != 0.
  - Next cycle: data_o/frame_err_o = mem[rd_ptr] and rd_valid_o=1; rd_ptr increments.
  - Latency is 1 clock from rd_en_i to data.
- Read on empty: ignored. rd_valid_o=0, data_o holds, no pointer change.
- rd_valid_o is 0 in every cycle not following an accepted read. data_o holds its value between reads.
- Write accept: wr_acc = wr_en_i && (level != DEPTH || rd_acc). On accept, mem[wr_ptr] <= {frame_err_i, data_i} and wr_ptr increments.
- Write on full without a same-cycle accepted read: byte dropped, overflow_o <= 1 in the next cycle, pointers and level unchanged.
- Level update:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged when both or neither occur
- Simultaneous read+write:
  - when empty: the write is accepted and the read is ignored (no bypass); level becomes 1.
  - when full: both are accepted; level stays DEPTH and overflow does not set.
  - otherwise: both are accepted and level is unchanged.
- Overflow priority within a non-reset, non-flush cycle:
  - a set condition beats ovf_clr_i in the same cycle
  - otherwise ovf_clr_i=1 clears overflow_o next cycle
- thresh_i > DEPTH: intr_thresh_o never asserts (no error).
- Wrap-around: after DEPTH accepted writes and reads the pointers return to 0, with ordering preserved across the wrap.
- Reset mid-operation: all in-flight state is discarded. The first read after reset returns the first byte written after reset.

Test Plan:
- Reset then idle -> level_o=0, intr_empty_o=1, intr_full_o=0, overflow_o=0, data_o=0, rd_valid_o=0.
- Write 0x11..0x18 (DEPTH=8), then 8 reads:
  - after the writes: intr_full_o=1, level_o=8
  - each read: data_o=0x11..0x18 in order, rd_valid_o one cycle after each rd_en_i
  - finally: intr_empty_o=1
- Overflow:
  - fill to 8, write 0xAA -> dropped; overflow_o=1 next cycle; reads return 0x11..0x18 with no 0xAA
  - ovf_clr_i pulse -> overflow_o=0
- Simultaneous rd+wr:
  - when full: level stays 8, overflow_o stays 0, data_o=oldest byte, new byte read out last
  - when empty: level becomes 1, rd_valid_o=0
- Watermark and frame error:
  - thresh_i=4: intr_thresh_o=0 at level 3 and 1 at level 4
  - thresh_i=0: intr_thresh_o never asserts
  - byte 0x55 written with frame_err_i=1 -> read returns data_o=0x55, frame_err_o=1
- Wrap and flush:
  - 20 interleaved write/read pairs -> order preserved across the pointer wrap
  - clr_i with level=5 plus same-cycle wr_en_i -> level_o=0, intr_empty_o=1, data_o holds its last value
